// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 panel path: SPI transmitter states and D/C flag values.
package ili9341_pkg;

  localparam int   ILI_DW   = 8;
  localparam logic ILI_CMD  = 1'b0;
  localparam logic ILI_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clk_tick.sv
// sclk half-period divider: strobes o_rise in the last clk of a low phase and o_fall
// in the last clk of a high phase. Cleared to the start of a low phase by i_clr.
module spi_clk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_half;
  logic             w_term;

  // With CLK_DIV=1 the counter stays at zero and every enabled cycle is terminal.
  assign w_term = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_half <= 1'b0;
    end else if (i_clr) begin
      r_div  <= '0;
      r_half <= 1'b0;
    end else if (i_en) begin
      if (w_term) begin
        r_div  <= '0;
        r_half <= ~r_half;
      end else begin
        r_div  <= r_div + DIV_W'(1);
      end
    end
  end

  assign o_rise = i_en & ~r_half & w_term;
  assign o_fall = i_en &  r_half & w_term;

endmodule

// File: rtl/spi_tx_ili9341.sv
// SPI mode-0 MSB-first byte transmitter for the ILI9341 (cs, dc, sclk, mosi).
// Optional macro SPI_CS_HOLD_EN: chain bytes with cs held low, skipping SETUP/HOLD.
module spi_tx_ili9341
  import ili9341_pkg::*;
#(
  parameter int DW       = ILI_DW,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          dc_in,
  input  logic          load,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          cs,
  output logic          dc,
  output logic          sclk,
  output logic          mosi
);

  localparam int BIT_W   = $clog2(DW + 1);
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  spi_state_t       r_state, w_state_nxt;
  logic [DW-1:0]    r_shreg, w_shreg_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_cs, r_dc, r_sclk, r_mosi, r_done, r_busy;
  logic             w_dc_nxt, w_sclk_nxt, w_mosi_nxt, w_done_nxt;
  logic             w_rise, w_fall, w_tick_en, w_tick_clr;
  logic             w_chain_ok, w_accept;

  assign w_tick_en = (r_state == ST_SHIFT);

  spi_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_tick_en),
    .i_clr (w_tick_clr),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

`ifdef SPI_CS_HOLD_EN
  // Last clk of the final high phase: a new byte can slot straight in.
  assign w_chain_ok = (r_state == ST_SHIFT) & w_fall & (r_bit == BIT_W'(1));
`else
  assign w_chain_ok = 1'b0;
`endif

  assign ready    = (r_state == ST_IDLE) | w_chain_ok;
  assign w_accept = load & ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit;
    w_cnt_nxt   = r_cnt;
    w_dc_nxt    = r_dc;
    w_sclk_nxt  = r_sclk;
    w_mosi_nxt  = r_mosi;
    w_done_nxt  = 1'b0;
    w_tick_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mosi_nxt = 1'b0;
        w_sclk_nxt = 1'b0;
        if (w_accept) begin
          w_shreg_nxt = data_in;
          w_dc_nxt    = dc_in;
          w_mosi_nxt  = data_in[DW-1];
          w_bit_nxt   = BIT_W'(DW);
          w_cnt_nxt   = CNT_W'(CS_SETUP - 1);
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_SHIFT;
          w_tick_clr  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_sclk_nxt = 1'b0;
          if (r_bit == BIT_W'(1)) begin
            if (w_accept) begin
              w_shreg_nxt = data_in;
              w_dc_nxt    = dc_in;
              w_mosi_nxt  = data_in[DW-1];
              w_bit_nxt   = BIT_W'(DW);
              w_done_nxt  = 1'b1;
            end else begin
              w_cnt_nxt   = CNT_W'(CS_HOLD - 1);
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_shreg_nxt = {r_shreg[DW-2:0], 1'b0};
            w_mosi_nxt  = r_shreg[DW-2];
            w_bit_nxt   = r_bit - BIT_W'(1);
          end
        end else if (w_rise) begin
          w_sclk_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_mosi_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit  <= '0;
      r_cnt  <= '0;
      r_cs   <= 1'b1;
      r_dc   <= 1'b1;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_bit  <= w_bit_nxt;
      r_cnt  <= w_cnt_nxt;
      r_cs   <= (w_state_nxt == ST_IDLE);
      r_dc   <= w_dc_nxt;
      r_sclk <= w_sclk_nxt;
      r_mosi <= w_mosi_nxt;
      r_done <= w_done_nxt;
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  // Shift data is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    r_shreg <= w_shreg_nxt;
  end

  assign cs   = r_cs;
  assign dc   = r_dc;
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign done = r_done;
  assign busy = r_busy;

endmodule

// File: tb/tb_spi_tx_ili9341.sv
// Directed bench for spi_tx_ili9341: default instance plus a CLK_DIV=1 instance.
module tb_spi_tx_ili9341;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_in;
  logic       dc_in, load;
  logic       ready, busy, done, cs, dc, sclk, mosi;

  logic [7:0] data_in_b;
  logic       dc_in_b, load_b;
  logic       ready_b, busy_b, done_b, cs_b, dc_b, sclk_b, mosi_b;

  int n_checks = 0;
  int n_fail   = 0;

  spi_tx_ili9341 u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dc_in(dc_in), .load(load),
    .ready(ready), .busy(busy), .done(done), .cs(cs), .dc(dc), .sclk(sclk), .mosi(mosi)
  );

  spi_tx_ili9341 #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in_b), .dc_in(dc_in_b), .load(load_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .cs(cs_b), .dc(dc_b), .sclk(sclk_b),
    .mosi(mosi_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads one byte on the default instance and records what the panel pins do until done.
  task automatic send_capture(input logic [7:0] b, input logic d, output int done_at,
                              output int rises, output logic [7:0] bits, output int cs_low,
                              output logic dc_ok);
    logic prev;
    prev = 1'b0; done_at = -1; rises = 0; bits = 8'h00; cs_low = 0; dc_ok = 1'b1;
    data_in = b; dc_in = d; load = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      load = 1'b0;
      if (cs === 1'b0) begin
        cs_low++;
        if (dc !== d) dc_ok = 1'b0;
      end
      if (sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[6:0], mosi};
      end
      prev = sclk;
      if (done === 1'b1) begin
        done_at = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; data_in = 8'h00; dc_in = 1'b0;
    load_b = 1'b0; data_in_b = 8'h00; dc_in_b = 1'b0;
    tick(); tick();
    n_checks++;
    if ({cs, dc, sclk, mosi, done, busy} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_outputs: got cs,dc,sclk,mosi,done,busy=%b expected 110000",
               {cs, dc, sclk, mosi, done, busy});
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (ready !== 1'b1 || cs !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b cs=%b expected 1 1", ready, cs);
    end
  endtask

  task automatic test_single();
    int done_at, rises, cs_low;
    logic [7:0] bits;
    logic dc_ok;
    send_capture(8'h2A, 1'b0, done_at, rises, bits, cs_low, dc_ok);
    n_checks++;
    if (done_at !== 35) begin n_fail++; $display("FAIL single_latency: got %0d expected 35", done_at); end
    n_checks++;
    if (rises !== 8) begin n_fail++; $display("FAIL single_rises: got %0d expected 8", rises); end
    n_checks++;
    if (bits !== 8'h2A) begin n_fail++; $display("FAIL single_bits: got %h expected 2a", bits); end
    n_checks++;
    if (cs_low !== 34) begin n_fail++; $display("FAIL single_cs_low: got %0d expected 34", cs_low); end
    n_checks++;
    if (dc_ok !== 1'b1) begin n_fail++; $display("FAIL single_dc: dc left 0 during cs low"); end
    n_checks++;
    if ({cs, mosi, busy, ready, dc} !== 5'b10010) begin
      n_fail++;
      $display("FAIL single_done_cycle: got cs,mosi,busy,ready,dc=%b expected 10010",
               {cs, mosi, busy, ready, dc});
    end
  endtask

  task automatic test_back_to_back();
    int done_at, rises, cs_low;
    logic [7:0] bits;
    logic dc_ok;
    send_capture(8'hFF, 1'b1, done_at, rises, bits, cs_low, dc_ok);
    n_checks++;
    if (done_at !== 35 || bits !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_first: got done_at=%0d bits=%h expected 35 ff", done_at, bits);
    end
    n_checks++;
    if (cs !== 1'b1) begin n_fail++; $display("FAIL b2b_cs_gap: got cs=%b expected 1", cs); end
    send_capture(8'h00, 1'b1, done_at, rises, bits, cs_low, dc_ok);
    n_checks++;
    if (done_at !== 35 || bits !== 8'h00 || rises !== 8 || dc_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got done_at=%0d bits=%h rises=%0d dc_ok=%b expected 35 00 8 1",
               done_at, bits, rises, dc_ok);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got done=%b expected 0", done); end
  endtask

`ifdef SPI_CS_HOLD_EN
  task automatic test_stream();
    int done_n, rises;
    int done_t[3];
    logic [23:0] bits;
    logic prev, cs_gap;
    done_n = 0; rises = 0; bits = 24'h0; prev = 1'b0; cs_gap = 1'b0;
    done_t[0] = -1; done_t[1] = -1; done_t[2] = -1;
    data_in = 8'h2C; dc_in = 1'b1; load = 1'b1;
    for (int c = 1; c <= 110; c++) begin
      tick();
      load    = (c == 33 || c == 65);
      data_in = (c == 33) ? 8'h12 : 8'h34;
      if (c == 33 || c == 65) begin
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, ready); end
      end
      if (c <= 98 && cs !== 1'b0) cs_gap = 1'b1;
      if (sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[22:0], mosi};
      end
      prev = sclk;
      if (done === 1'b1) begin
        if (done_n < 3) done_t[done_n] = c;
        done_n++;
      end
    end
    n_checks++;
    if (cs_gap !== 1'b0) begin n_fail++; $display("FAIL stream_cs: cs went high inside the stream"); end
    n_checks++;
    if (rises !== 24 || bits !== 24'h2C1234) begin
      n_fail++;
      $display("FAIL stream_bits: got rises=%0d bits=%h expected 24 2c1234", rises, bits);
    end
    n_checks++;
    if (done_n !== 3 || done_t[0] !== 34 || done_t[1] !== 66 || done_t[2] !== 99) begin
      n_fail++;
      $display("FAIL stream_done: got n=%0d at %0d,%0d,%0d expected 3 at 34,66,99",
               done_n, done_t[0], done_t[1], done_t[2]);
    end
  endtask
`else
  task automatic test_no_chain();
    int done_n, done_at, rises;
    logic [7:0] bits;
    logic prev;
    done_n = 0; done_at = -1; rises = 0; bits = 8'h00; prev = 1'b0;
    data_in = 8'h2C; dc_in = 1'b1; load = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      load    = (c == 33);
      data_in = 8'h12;
      if (c == 33) begin
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL nochain_ready: got %b expected 0", ready); end
      end
      if (sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[6:0], mosi};
      end
      prev = sclk;
      if (done === 1'b1) begin
        done_n++;
        done_at = c;
      end
    end
    n_checks++;
    if (done_n !== 1 || done_at !== 35 || bits !== 8'h2C || rises !== 8) begin
      n_fail++;
      $display("FAIL nochain_done: got n=%0d at=%0d bits=%h rises=%0d expected 1 35 2c 8",
               done_n, done_at, bits, rises);
    end
    n_checks++;
    if (cs !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nochain_idle: got cs=%b busy=%b expected 1 0", cs, busy);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int rises, done_at, cs_low;
    logic [7:0] bits;
    logic prev, dc_ok, saw_done;
    rises = 0; prev = 1'b0; saw_done = 1'b0;
    data_in = 8'hA5; dc_in = 1'b1; load = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      load = 1'b0;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      if (rises == 3) break;
    end
    n_checks++;
    if (rises !== 3) begin n_fail++; $display("FAIL rstmid_reach: got %0d rises expected 3", rises); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cs, sclk, mosi, done, busy} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_async: got cs,sclk,mosi,done,busy=%b expected 10000",
               {cs, sclk, mosi, done, busy});
    end
    tick(); tick();
    rst = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done !== 1'b0 || cs !== 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: done or cs activity after abort"); end
    send_capture(8'h5A, 1'b1, done_at, rises, bits, cs_low, dc_ok);
    n_checks++;
    if (done_at !== 35 || bits !== 8'h5A || rises !== 8 || cs_low !== 34) begin
      n_fail++;
      $display("FAIL rstmid_next: got done_at=%0d bits=%h rises=%0d cs_low=%0d expected 35 5a 8 34",
               done_at, bits, rises, cs_low);
    end
  endtask

  task automatic test_clkdiv1();
    int done_at, rises, sclk_err;
    logic [7:0] bits;
    logic prev;
    done_at = -1; rises = 0; sclk_err = 0; bits = 8'h00; prev = 1'b0;
    data_in_b = 8'h81; dc_in_b = 1'b0; load_b = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      load_b = 1'b0;
      if (c >= 2 && c <= 18 && sclk_b !== ((c % 2 == 1) && c <= 17)) sclk_err++;
      if (sclk_b === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[6:0], mosi_b};
      end
      prev = sclk_b;
      if (done_b === 1'b1) begin
        done_at = c;
        break;
      end
    end
    n_checks++;
    if (done_at !== 19) begin n_fail++; $display("FAIL div1_latency: got %0d expected 19", done_at); end
    n_checks++;
    if (bits !== 8'h81 || rises !== 8) begin
      n_fail++;
      $display("FAIL div1_bits: got bits=%h rises=%0d expected 81 8", bits, rises);
    end
    n_checks++;
    if (sclk_err !== 0) begin n_fail++; $display("FAIL div1_sclk: got %0d bad cycles expected 0", sclk_err); end
  endtask

  task automatic test_load_held();
    int done_n, done_at, rises, rdy_err;
    logic [7:0] bits;
    logic prev;
    done_n = 0; done_at = -1; rises = 0; rdy_err = 0; bits = 8'h00; prev = 1'b0;
    data_in = 8'h3C; dc_in = 1'b1; load = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      load    = (c <= 32);
      data_in = 8'hC3;
      dc_in   = 1'b0;
      if ((c <= 32 || c == 34) && ready !== 1'b0) rdy_err++;
      if (sclk === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[6:0], mosi};
      end
      prev = sclk;
      if (done === 1'b1) begin
        done_n++;
        done_at = c;
      end
    end
    n_checks++;
    if (rdy_err !== 0) begin n_fail++; $display("FAIL held_ready: got %0d busy cycles with ready=1 expected 0", rdy_err); end
    n_checks++;
    if (done_n !== 1 || done_at !== 35) begin
      n_fail++;
      $display("FAIL held_accepts: got %0d done pulses last at %0d expected 1 at 35", done_n, done_at);
    end
    n_checks++;
    if (bits !== 8'h3C || rises !== 8 || dc !== 1'b1) begin
      n_fail++;
      $display("FAIL held_data: got bits=%h rises=%0d dc=%b expected 3c 8 1", bits, rises, dc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef SPI_CS_HOLD_EN
    test_stream();
`else
    test_no_chain();
`endif
    test_reset_mid();
    test_clkdiv1();
    test_load_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
